// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style main controller: state sequencing, control decode,
// memory-wait timeout and sticky fault state.
module multicycle_ctrl #(
  parameter logic [6:0]  LOAD    = 7'd3,
  parameter logic [6:0]  I_AL    = 7'd19,
  parameter logic [6:0]  JALR    = 7'd103,
  parameter logic [6:0]  STORE   = 7'd35,
  parameter logic [6:0]  REG     = 7'd51,
  parameter logic [6:0]  BRANCH  = 7'd99,
  parameter logic [6:0]  AUIPC   = 7'd23,
  parameter logic [6:0]  LUI     = 7'd55,
  parameter logic [6:0]  JAL     = 7'd111,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_FAULT    = 4'd15
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] wait_cnt;
  logic          req;

  assign req   = (cur == S_FETCH) || (cur == S_MEMREAD) || (cur == S_MEMWRITE);
  assign state = cur;

  // Next-state selection, with the wait timeout overriding a stalled access
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          LOAD, STORE: nxt = S_MEMADR;
          REG:         nxt = S_EXEC_R;
          I_AL:        nxt = S_EXEC_I;
          BRANCH:      nxt = S_BEQ;
          JAL:         nxt = S_JAL;
          JALR:        nxt = S_JALR;
          LUI, AUIPC:  nxt = S_UPPER;
          default:     nxt = S_FAULT;
        endcase
      end
      S_MEMADR:   nxt = (op == LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
      S_EXEC_R:   nxt = S_ALUWB;
      S_EXEC_I:   nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_JALR:     nxt = S_JAL;
      S_UPPER:    nxt = S_ALUWB;
      default:    nxt = S_FAULT;
    endcase
    if ((TIMEOUT > 0) && req && !mem_ready && (wait_cnt == LAST)) nxt = S_FAULT;
  end

  // Control decode from the current state; reset masks every side-effecting strobe
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (cur)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_UPPER: begin
        alu_src_a = (op == LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
      reg_write = 1'b0;
    end
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    imm_src = 3'b000;
    case (op)
      STORE:      imm_src = 3'b001;
      BRANCH:     imm_src = 3'b010;
      LUI, AUIPC: imm_src = 3'b011;
      JAL:        imm_src = 3'b100;
      default:    imm_src = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
    end else begin
      cur     <= nxt;
      illegal <= (nxt == S_FAULT);
      if ((nxt != cur) || mem_ready) wait_cnt <= '0;
      else if (req)                  wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against a per-class state-sequence model.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_I_AL   = 7'd19;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_JAL    = 7'd111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = OP_REG;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, branch, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic [3:0] state;
  logic [17:0] ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .imm_src(imm_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign ctrl = {mem_req, mem_we, adr_src, ir_write, pc_write, branch, reg_write,
                 alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal};

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    if (o == OP_STORE) return 3'b001;
    if (o == OP_BRANCH) return 3'b010;
    if (o == OP_LUI || o == OP_AUIPC) return 3'b011;
    if (o == OP_JAL) return 3'b100;
    return 3'b000;
  endfunction

  // Expected control word from the documented per-state output table
  function automatic logic [17:0] exp_ctrl(input int s, input logic [6:0] o,
                                           input logic rdy, input logic r);
    logic mreq, we, adr, irw, pcw, br, rw, ill;
    logic [1:0] sa, sb, ao, rs;
    {mreq, we, adr, irw, pcw, br, rw, ill} = 8'h00;
    {sa, sb, ao, rs} = 8'h00;
    case (s)
      0:  begin mreq = 1; sb = 2; rs = 2; irw = rdy; pcw = rdy; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin rs = 1; rw = 1; end
      5:  begin mreq = 1; we = 1; adr = 1; end
      6:  begin sa = 2; ao = 2; end
      7:  begin sa = 2; sb = 1; ao = 2; end
      8:  rw = 1;
      9:  begin sa = 2; ao = 1; br = 1; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      11: begin sa = 2; sb = 1; end
      12: begin sa = (o == OP_LUI) ? 2'd3 : 2'd1; sb = 1; end
      15: ill = 1;
      default: ;
    endcase
    if (r) {mreq, we, irw, pcw, br, rw} = 6'h00;
    return {mreq, we, adr, irw, pcw, br, rw, sa, sb, ao, rs, exp_imm(o), ill};
  endfunction

  // Runs one instruction from FETCH; waits give the ready cycle index in memory states
  task automatic run_op(input logic [6:0] o, input int w_fetch, input int w_mem,
                        output bit faulted);
    int seq[$];
    int w;
    bit mem;
    logic rdy;
    logic [17:0] e;
    seq = {0, 1};
    case (o)
      OP_LOAD:            begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      OP_STORE:           begin seq.push_back(2); seq.push_back(5); end
      OP_REG:             begin seq.push_back(6); seq.push_back(8); end
      OP_I_AL:            begin seq.push_back(7); seq.push_back(8); end
      OP_BRANCH:          seq.push_back(9);
      OP_JAL:             begin seq.push_back(10); seq.push_back(8); end
      OP_JALR:            begin seq.push_back(11); seq.push_back(10); seq.push_back(8); end
      OP_LUI, OP_AUIPC:   begin seq.push_back(12); seq.push_back(8); end
      default:            seq.push_back(15);
    endcase
    faulted = 1'b0;
    for (int p = 0; p < seq.size(); p++) begin
      mem = (seq[p] == 0) || (seq[p] == 3) || (seq[p] == 5);
      w = (seq[p] == 0) ? w_fetch : w_mem;
      for (int k = 0; k <= int'(TO); k++) begin
        rdy = mem ? (k == w) : 1'($urandom_range(0, 1));
        @(negedge clk);
        rst = 1'b0; op = o; mem_ready = rdy;
        #1;
        e = exp_ctrl(seq[p], o, rdy, 1'b0);
        n_checks++;
        if (state !== 4'(seq[p])) begin
          n_fail++;
          $display("FAIL state op=%0d step=%0d cyc=%0d: got %0d want %0d", o, p, k, state, seq[p]);
        end
        n_checks++;
        if (ctrl !== e) begin
          n_fail++;
          $display("FAIL ctrl op=%0d st=%0d cyc=%0d: got %b want %b", o, seq[p], k, ctrl, e);
        end
        if (seq[p] == 15) begin faulted = 1'b1; return; end
        if (!mem || rdy) break;
        if (k == int'(TO) - 1) begin
          @(negedge clk);
          op = o; mem_ready = 1'($urandom_range(0, 1));
          #1;
          e = exp_ctrl(15, o, mem_ready, 1'b0);
          n_checks++;
          if (state !== 4'd15 || ctrl !== e) begin
            n_fail++;
            $display("FAIL timeout op=%0d st=%0d: got state %0d ctrl %b want 15 %b", o, seq[p], state, ctrl, e);
          end
          faulted = 1'b1;
          return;
        end
      end
    end
  endtask

  // Stays in FAULT for n cycles under random inputs, then applies one reset cycle
  task automatic recover(input int n);
    logic [17:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; op = 7'($urandom); mem_ready = 1'($urandom_range(0, 1));
      #1;
      e = exp_ctrl(15, op, mem_ready, 1'b0);
      n_checks++;
      if (state !== 4'd15 || ctrl !== e) begin
        n_fail++;
        $display("FAIL fault_hold cyc=%0d: got state %0d ctrl %b want 15 %b", i, state, ctrl, e);
      end
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    e = exp_ctrl(15, op, 1'b1, 1'b1);
    n_checks++;
    if (state !== 4'd15 || ctrl !== e) begin
      n_fail++;
      $display("FAIL fault_rst: got state %0d ctrl %b want 15 %b", state, ctrl, e);
    end
  endtask

  task automatic test_reset();
    logic [17:0] e;
    rst = 1'b1; op = OP_REG; mem_ready = 1'b0;
    @(negedge clk); #1;
    e = exp_ctrl(0, OP_REG, 1'b0, 1'b1);
    n_checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got state %0d illegal %b want 0 0", state, illegal);
    end
    n_checks++;
    if (ctrl !== e) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want %b", ctrl, e);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    e = exp_ctrl(0, OP_REG, 1'b1, 1'b1);
    n_checks++;
    if (ctrl !== e) begin
      n_fail++;
      $display("FAIL reset_mask_ready: got %b want %b", ctrl, e);
    end
  endtask

  task automatic test_classes();
    bit f;
    logic [6:0] ops[9] = '{OP_REG, OP_LOAD, OP_JALR, OP_STORE, OP_I_AL,
                           OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC};
    int wm[9] = '{0, 3, 0, 2, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], i % 2, wm[i], f);
      n_checks++;
      if (f !== 1'b0) begin
        n_fail++;
        $display("FAIL class_nofault op=%0d: got fault %b want 0", ops[i], f);
      end
    end
  endtask

  task automatic test_illegal();
    bit f;
    run_op(7'h7F, 0, 0, f);
    n_checks++;
    if (f !== 1'b1 || illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_op: got fault %b illegal %b want 1 1", f, illegal);
    end
    recover(10);
  endtask

  task automatic test_timeout();
    bit f;
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    run_op(OP_REG, 10, 0, f);
    n_checks++;
    if (f !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_timeout: got fault %b want 1", f);
    end
    recover(1);
    run_op(OP_REG, int'(TO) - 1, 0, f);
    n_checks++;
    if (f !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_last_ready: got fault %b want 0", f);
    end
    run_op(OP_LOAD, 0, int'(TO), f);
    n_checks++;
    if (f !== 1'b1) begin
      n_fail++;
      $display("FAIL load_timeout: got fault %b want 1", f);
    end
    recover(2);
    run_op(OP_STORE, 0, int'(TO) - 1, f);
    n_checks++;
    if (f !== 1'b0) begin
      n_fail++;
      $display("FAIL store_last_ready: got fault %b want 0", f);
    end
  endtask

  task automatic test_mid_reset();
    int exp_s[5] = '{0, 1, 2, 5, 5};
    logic [17:0] e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = (i == 4); op = OP_STORE; mem_ready = (i == 0);
      #1;
      e = exp_ctrl(exp_s[i], OP_STORE, mem_ready, rst);
      n_checks++;
      if (state !== 4'(exp_s[i]) || ctrl !== e) begin
        n_fail++;
        $display("FAIL mid_reset cyc=%0d: got state %0d ctrl %b want %0d %b", i, state, ctrl, exp_s[i], e);
      end
    end
    n_checks++;
    if ({mem_we, mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_strobes: got we/req %b%b want 00", mem_we, mem_req);
    end
  endtask

  task automatic test_random();
    bit f;
    logic [6:0] o;
    logic [6:0] pool[11] = '{OP_REG, OP_LOAD, OP_JALR, OP_STORE, OP_I_AL, OP_BRANCH,
                             OP_JAL, OP_LUI, OP_AUIPC, 7'h7F, 7'h00};
    for (int i = 0; i < 40; i++) begin
      o = pool[$urandom_range(0, 10)];
      run_op(o, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), f);
      if (f) recover(int'($urandom_range(1, 3)));
    end
    run_op(OP_REG, 0, 0, f);
    n_checks++;
    if (f !== 1'b0) begin
      n_fail++;
      $display("FAIL random_tail: got fault %b want 0", f);
    end
  endtask

  initial begin
    test_reset();
    test_classes();
    test_illegal();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
